pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Elastic pipeline stage register for the RISC-V core. It sits between two pipeline stages, for example IF→ID or ID→EX, and replaces a plain always-load register wherever the downstream stage can stall. It carries one `DW`-bit payload with a valid/ready handshake on both sides, and a two-entry skid buffer keeps full throughput with registered `in_ready`. An optional flush kills in-flight entries and drives the bubble value (NOP) onto the output.

## Interface
Parameters:
- `DW`, 32, payload width in bits.
- `RST_VAL`, 32'h0000_0013, bubble value driven on `out_data` after reset or flush (RV32I NOP, `addi x0,x0,0`). Truncated or zero-extended to `DW`.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: synchronous kill of all held entries.
- `in_valid` input 1: upstream offers `in_data`.
- `in_ready` output 1: stage can accept. Registered.
- `in_data` input DW: upstream payload.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output DW: payload to downstream. Registered.
- `occupancy` output 2: number of held entries, 0 to 2.

## Operation
- Storage: main register `M` drives `out_data`, and skid register `S` holds overflow. Valid bits are `m_v` and `s_v`.
- Handshake events:
  - in-fire = `in_valid & in_ready`.
  - out-fire = `out_valid & out_ready`.
- Output mapping: `out_valid = m_v`, `in_ready = ~s_v`, `occupancy = m_v + s_v`.
- State machine, three states:
  - EMPTY: `m_v=0`, `s_v=0`.
    - in-fire → `M<=in_data`, go to FULL.
    - No in-fire → stay; `out_data` holds its last value.
  - FULL: `m_v=1`, `s_v=0`.
    - in-fire and out-fire → `M<=in_data`, stay FULL.
    - in-fire only → `S<=in_data`, go to SKID.
    - out-fire only → go to EMPTY; `M` holds its value.
    - Neither → hold.
  - SKID: `m_v=1`, `s_v=1`, `in_ready=0`.
    - out-fire → `M<=S`, go to FULL.
    - No out-fire → hold.
- Ordering: data leaves strictly in acceptance order; no entry is duplicated or dropped except by flush.
- `out_data` is stable while `out_valid & ~out_ready`.
- Flush, highest priority after reset: on the next edge `m_v=0`, `s_v=0`, `M<=RST_VAL`, go to EMPTY.
  - An in-fire in the flush cycle is discarded.
  - An out-fire in the flush cycle completes normally; downstream has already sampled it.
- `in_data` is not examined unless `in_valid=1`.

## Timing
- Reset values, asserted asynchronously: `out_valid=0`, `out_data=RST_VAL`, `in_ready=1`, `occupancy=0`, `S=RST_VAL`.
- Latency: in-fire at edge N gives `out_valid=1` with that data after edge N, one cycle.
- Throughput: one transfer per cycle while `out_ready=1`.
- Stall propagation: `in_ready` drops one cycle after the first stalled in-fire. The skid entry absorbs the beat accepted in that cycle.
- `in_ready` and `out_valid` depend only on registers; there is no combinational in→out path.
- Reset mid-operation clears both entries immediately, without waiting for a clock edge.
- After `rst_n` deasserts, the first accept can occur on the first rising edge.
- Flush while in SKID: `in_ready=1` in the cycle after the flush edge.

## Configuration
- Macro `PIPE_SKID_FLUSH_EN`.
- Defined: `flush` behaves as described above.
- Undefined: `flush` is ignored and no flush logic is synthesized. The port remains so instantiations stay unchanged.

## Test plan
- Reset with `rst_n=0` mid-stream (state SKID) → immediately `out_valid=0`, `in_ready=1`, `out_data=32'h13`, `occupancy=0`.
- Streaming with `out_ready=1`: drive `in_data` 0x100, 0x104, 0x108 on consecutive cycles with `in_valid=1` → `out_data` shows the same sequence one cycle later, with `in_ready` held at 1.
- Backpressure:
  - Stimulus: hold `out_ready=0` while sending 0xA, then 0xB.
  - Required response: `occupancy` reaches 2, `in_ready=0`, and `out_data` stays 0xA.
  - Then release `out_ready` → outputs 0xA then 0xB, `in_ready` returns to 1 and no beat is lost.
- Simultaneous events: in FULL holding 0x1, in-fire 0x2 and out-fire in the same cycle → `occupancy` stays 1 and `out_data`=0x2 on the next cycle.
- Flush with `PIPE_SKID_FLUSH_EN` defined:
  - Stimulus: in SKID holding 0xA/0xB, assert `flush` together with `in_valid`=1 and data 0xC.
  - Required response: next cycle `out_valid=0`, `out_data=32'h13`, `occupancy=0`, and 0xC never appears at the output.
- Flush with the macro undefined: same stimulus → `flush` has no effect, and the output sequence is 0xA, 0xB.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Elastic pipeline stage register placed between two core pipeline stages
// (e.g. IF->ID, ID->EX) wherever the downstream stage can stall. One DW-bit
// payload moves with a valid/ready handshake on both sides. A two-entry
// arrangement (main register M plus skid register S) sustains one transfer per
// cycle while keeping in_ready a pure function of registered state.
//
// Optional feature:
//   `define PIPE_SKID_FLUSH_EN  -> flush kills all held entries and drives the
//                                 bubble value RST_VAL onto out_data.
//   (undefined)                -> flush is ignored; the port is kept so that
//                                 instantiations do not change.
//
// Parameters:
//   DW       payload width in bits
//   RST_VAL  bubble value (RV32I NOP by default), truncated/zero-extended to DW
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   flush      in   1   synchronous kill of held entries (see macro above)
//   in_valid   in   1   upstream offers in_data
//   in_ready   out  1   stage can accept (registered)
//   in_data    in   DW  upstream payload
//   out_valid  out  1   out_data is valid (registered)
//   out_ready  in   1   downstream accepts
//   out_data   out  DW  payload to downstream (registered)
//   occupancy  out  2   number of held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
   parameter int          DW      = 32,
   parameter logic [31:0] RST_VAL = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [1:0]    occupancy
);

   // Bubble value resized to the payload width.
   localparam logic [DW-1:0] BUBBLE = DW'(RST_VAL);

   // Encoding chosen so that bit 0 is the main-valid flag and bit 1 the
   // skid-valid flag; the handshake outputs are then plain register bits.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL  = 2'b01,
      SKID  = 2'b11
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] m_q, m_d;
   logic [DW-1:0] s_q, s_d;

   logic m_v, s_v;
   logic in_fire, out_fire;
   logic kill;

`ifdef PIPE_SKID_FLUSH_EN
   assign kill = flush;
`else
   // Flush compiled out: the port stays but drives nothing.
   logic unused_flush;
   assign unused_flush = flush;
   assign kill         = 1'b0;
`endif

   assign m_v = state_q[0];
   assign s_v = state_q[1];

   assign out_valid = m_v;
   assign in_ready  = ~s_v;
   assign out_data  = m_q;
   assign occupancy = {1'b0, m_v} + {1'b0, s_v};

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Next-state and datapath steering. An out-fire during a flush cycle needs
   // no special handling: downstream has already sampled M this cycle.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;

      if (kill) begin
         state_d = EMPTY;
         m_d     = BUBBLE;
         s_d     = BUBBLE;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  m_d     = in_data;
                  state_d = FULL;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  m_d = in_data;
               end else if (in_fire) begin
                  // Downstream stalled: park the new beat behind M.
                  s_d     = in_data;
                  state_d = SKID;
               end else if (out_fire) begin
                  // M keeps its value so out_data stays quiet when idle.
                  state_d = EMPTY;
               end
            end
            SKID: begin
               if (out_fire) begin
                  m_d     = s_q;
                  state_d = FULL;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         m_q     <= BUBBLE;
         s_q     <= BUBBLE;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         s_q     <= s_d;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Scoreboard bench for pipe_skid_reg. The reference model is an ordered queue
// of accepted beats with capacity two: a beat is accepted when offered and
// fewer than two are held, the oldest beat is presented and leaves when
// downstream is ready, and a flush (when PIPE_SKID_FLUSH_EN is defined)
// empties the queue and restores the bubble value.
// The driver acts 1 time unit after each rising edge and commits the
// previous cycle's accept/flush; the monitor acts on the falling edge, checks
// status outputs and pops/compares the beat that leaves on the next edge.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

   localparam logic [31:0] RST = 32'h0000_0013;
`ifdef PIPE_SKID_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;

   pipe_skid_reg #(.DW(32), .RST_VAL(RST)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .occupancy(occupancy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [31:0] sb[$];       // beats held by the stage, oldest first
   logic [31:0] idle_val;    // out_data expected while nothing is held
   bit          pend_v;      // beat accepted on the coming edge
   logic [31:0] pend_d;
   bit          pend_fl;     // flush takes effect on the coming edge
   bit          run;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: outputs are stable here, and out_ready already holds the value
   // that governs the next edge.
   always @(negedge clk) begin
      if (run && rst_n) begin
         chk("occupancy", {30'd0, occupancy}, sb.size());
         chk("in_ready", {31'd0, in_ready}, (sb.size() < 2) ? 32'd1 : 32'd0);
         chk("out_valid", {31'd0, out_valid}, (sb.size() > 0) ? 32'd1 : 32'd0);
         if (sb.size() == 0) begin
            chk("idle_data", out_data, idle_val);
         end else begin
            chk("out_data", out_data, sb[0]);
            if (out_ready) idle_val = sb.pop_front();
         end
      end
   end

   task automatic commit();
      if (pend_fl) begin
         sb.delete();
         idle_val = RST;
      end else if (pend_v) begin
         sb.push_back(pend_d);
      end
      pend_v  = 1'b0;
      pend_fl = 1'b0;
   endtask

   task automatic drive(input logic iv, input logic [31:0] id,
                        input logic ordy, input logic fl);
      commit();
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      pend_v    = iv && (sb.size() < 2);
      pend_d    = id;
      pend_fl   = fl && FLUSH_EN;
   endtask

   task automatic step(input logic iv, input logic [31:0] id,
                       input logic ordy, input logic fl);
      @(posedge clk);
      #1;
      drive(iv, id, ordy, fl);
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      sb.delete();
      idle_val  = RST;
      pend_v    = 1'b0;
      pend_d    = '0;
      pend_fl   = 1'b0;
      run       = 1'b0;

      // Power-on reset.
      #3 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_data",  out_data, RST);
      chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      run = 1'b1;

      // Streaming at full rate.
      step(1'b1, 32'h100, 1'b1, 1'b0);
      step(1'b1, 32'h104, 1'b1, 1'b0);
      step(1'b1, 32'h108, 1'b1, 1'b0);
      drain();

      // Backpressure: fill M and S, hold, then release.
      step(1'b1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      drain();

      // Simultaneous in-fire and out-fire while FULL.
      step(1'b1, 32'h1, 1'b0, 1'b0);
      step(1'b1, 32'h2, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      drain();

      // Flush while in SKID with a new beat offered.
      step(1'b1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0);
      step(1'b1, 32'hC, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      drain();

      // Flush from FULL with an out-fire and an offered beat in the same cycle.
      step(1'b1, 32'h33, 1'b0, 1'b0);
      step(1'b1, 32'h44, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      drain();

      // Asynchronous reset while in SKID, then accept on the first edge.
      step(1'b1, 32'h5A, 1'b0, 1'b0);
      step(1'b1, 32'h5B, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("async_rst_out_data",  out_data, RST);
      chk("async_rst_occupancy", {30'd0, occupancy}, 32'd0);
      sb.delete();
      idle_val = RST;
      pend_v   = 1'b0;
      pend_fl  = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b1, 32'h55, 1'b1, 1'b0);
      drain();

      // Randomized traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
              $urandom,
              ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
              ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      end
      drain();
      step(1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("final_held", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
